// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the unified-SRAM port arbiter.
//   size_e      : data access size encoding (byte/half/word/reserved)
//   OWNER_*     : response owner tag carried through the response stage
//   store_wen() : byte-lane enables for an aligned store, zero when misaligned
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    // Misaligned half/word and the reserved size yield no lanes: the write is
    // dropped here while the handshake still completes; the fault is raised upstream.
    function automatic logic [3:0] store_wen(input size_e sz, input logic [1:0] off);
        logic [3:0] wen;
        wen = 4'b0000;
        case (sz)
            SIZE_BYTE: wen = 4'b0001 << off;
            SIZE_HALF: wen = off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
            SIZE_WORD: wen = (off == 2'b00) ? 4'b1111 : 4'b0000;
            default:   wen = 4'b0000;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/sram_wen_gen.sv
// Combinational store formatter: byte enables and lane-replicated write data.
//   size_i     : access size (size_e encoding)
//   addr_lo_i  : byte offset within the word
//   wr_i       : 1 = store; loads produce no enables
//   wdata_i    : right-aligned store data
//   wen_o      : SRAM byte write enables
//   wdata_o    : store data replicated across all lanes of its size
module sram_wen_gen
    import sram_port_arbiter_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        wr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  wen_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        wen_o   = wr_i ? store_wen(size_e'(size_i), addr_lo_i) : 4'b0000;
        wdata_o = wdata_i;
        case (size_e'(size_i))
            SIZE_BYTE: wdata_o = {4{wdata_i[7:0]}};
            SIZE_HALF: wdata_o = {2{wdata_i[15:0]}};
            default:   wdata_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates the instruction-fetch port and the data port onto one
// single-port synchronous SRAM, one access per cycle, 1-cycle response.
//   clk, resetn                : clock, async active-low reset
//   inst_req/addr              : fetch request (read only)
//   inst_addr_ok/data_ok/rdata : fetch accept, response valid, read word
//   data_req/wr/size/addr/wdata: data request
//   data_addr_ok/data_ok/rdata : data accept, response valid, raw read word
//   sram_en/wen/addr/wdata     : SRAM command
//   sram_rdata                 : SRAM read data, one cycle after sram_en
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic          resp_valid_q, resp_valid_d;
    logic          resp_owner_q, resp_owner_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          grant_d, grant_i;
    logic [31:0]   addr_mux;
    logic [3:0]    wen_fmt;
    logic [31:0]   wdata_fmt;

    // Grants are gated by resetn so nothing reaches the SRAM while reset is held.
    always_comb begin
        grant_d = resetn & data_req & ~(inst_req & (starve_q == LIMIT));
        grant_i = resetn & inst_req & ~grant_d;
    end

    sram_wen_gen u_wen_gen (
        .size_i    (data_size),
        .addr_lo_i (data_addr[1:0]),
        .wr_i      (data_wr),
        .wdata_i   (data_wdata),
        .wen_o     (wen_fmt),
        .wdata_o   (wdata_fmt)
    );

    always_comb begin
        addr_mux     = grant_d ? data_addr : inst_addr;
        sram_en      = grant_i | grant_d;
        sram_addr    = addr_mux & 32'hFFFF_FFFC;
        sram_wen     = grant_d ? wen_fmt : 4'b0000;
        sram_wdata   = wdata_fmt;
        inst_addr_ok = grant_i;
        data_addr_ok = grant_d;
    end

    // Fetch is only "starved" while it is actually waiting behind a data grant.
    always_comb begin
        starve_d     = '0;
        resp_valid_d = sram_en;
        resp_owner_d = grant_d ? OWNER_DATA : OWNER_INST;
        if (grant_d && inst_req)
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWNER_INST;
            starve_q     <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            starve_q     <= starve_d;
        end
    end

    always_comb begin
        inst_data_ok = resp_valid_q & (resp_owner_q == OWNER_INST);
        data_data_ok = resp_valid_q & (resp_owner_q == OWNER_DATA);
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = 32'h0;

    int pass_cnt = 0;
    int total    = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // SRAM model: unwritten words read as addr ^ 5A5A5A5A.
    logic [31:0] mem [logic [29:0]];
    logic [31:0] mw;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            mw = mem.exists(sram_addr[31:2]) ? mem[sram_addr[31:2]] : init_word(sram_addr);
            if (|sram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) mw[8*b +: 8] = sram_wdata[8*b +: 8];
                mem[sram_addr[31:2]] = mw;
            end else begin
                sram_rdata <= mw;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    endtask

    task automatic dreq(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
        data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
    endtask

    logic       exp_d, prev_d;
    logic [31:0] prev_a, cur_a;

    initial begin
        resetn = 1'b0; inst_addr = '0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        idle();
        // Requests held during reset must not leak to the SRAM or handshakes.
        inst_req = 1'b1; data_req = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
        check("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        check("rst_sram_en", {31'b0, sram_en}, 32'd0);
        check("rst_sram_wen", {28'b0, sram_wen}, 32'd0);
        check("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
        idle();

        // 1. single fetch
        @(negedge clk); resetn = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #1;
        check("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
        check("t1_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        check("t1_sram_addr", sram_addr, 32'hBFC0_0000);
        check("t1_sram_wen", {28'b0, sram_wen}, 32'd0);
        check("t1_no_ok_yet", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
        @(negedge clk); idle(); #1;
        check("t1_inst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd2);
        check("t1_inst_rdata", inst_rdata, 32'hE59A_5A5A);

        // 2. both requesting every cycle: pattern d,d,d,d,i repeating
        prev_d = 1'b0; prev_a = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            inst_req = 1'b1; inst_addr = 32'h3000 + 32'(4*k);
            dreq(1'b0, 2'd2, 32'h2000 + 32'(4*k), 32'h0);
            #1;
            exp_d = (k % 5) != 4;
            cur_a = exp_d ? 32'h2000 + 32'(4*k) : 32'h3000 + 32'(4*k);
            check($sformatf("t2_grant_d[%0d]", k), {30'b0, data_addr_ok, inst_addr_ok},
                  exp_d ? 32'd2 : 32'd1);
            check($sformatf("t2_sram_addr[%0d]", k), sram_addr, cur_a);
            if (k > 0) begin
                check($sformatf("t2_owner[%0d]", k), {30'b0, data_data_ok, inst_data_ok},
                      prev_d ? 32'd2 : 32'd1);
                check($sformatf("t2_rdata[%0d]", k), prev_d ? data_rdata : inst_rdata,
                      init_word(prev_a));
            end
            prev_d = exp_d; prev_a = cur_a;
        end

        // 3. byte/half stores, then read back the merged word
        @(negedge clk); idle(); dreq(1'b1, 2'd0, 32'h1003, 32'h0000_00A5); #1;
        check("t3_byte_wen", {28'b0, sram_wen}, 32'b1000);
        check("t3_byte_wdata", sram_wdata, 32'hA5A5_A5A5);
        check("t3_byte_addr", sram_addr, 32'h1000);
        @(negedge clk); dreq(1'b1, 2'd1, 32'h1002, 32'h0000_1234); #1;
        check("t3_half_wen", {28'b0, sram_wen}, 32'b1100);
        check("t3_half_wdata", sram_wdata, 32'h1234_1234);
        check("t3_byte_done", {31'b0, data_data_ok}, 32'd1);
        @(negedge clk); dreq(1'b1, 2'd0, 32'h2000, 32'h0); #1;
        check("t3_byte0_wen", {28'b0, sram_wen}, 32'b0001);
        @(negedge clk); dreq(1'b1, 2'd1, 32'h2000, 32'h0); #1;
        check("t3_half0_wen", {28'b0, sram_wen}, 32'b0011);
        @(negedge clk); dreq(1'b1, 2'd3, 32'h2000, 32'h0); #1;
        check("t3_rsvd_wen", {28'b0, sram_wen}, 32'b0000);
        check("t3_rsvd_accept", {31'b0, data_addr_ok}, 32'd1);
        @(negedge clk); dreq(1'b1, 2'd1, 32'h2001, 32'h0); #1;
        check("t3_half_mis_wen", {28'b0, sram_wen}, 32'b0000);

        // 4. misaligned word store is dropped but still completes
        @(negedge clk); dreq(1'b1, 2'd2, 32'h1001, 32'hDEAD_BEEF); #1;
        check("t4_mis_wen", {28'b0, sram_wen}, 32'b0000);
        check("t4_mis_accept", {31'b0, data_addr_ok}, 32'd1);
        @(negedge clk); dreq(1'b0, 2'd2, 32'h1000, 32'h0); #1;
        check("t4_mis_done", {31'b0, data_data_ok}, 32'd1);
        @(negedge clk); idle(); dreq(1'b1, 2'd2, 32'h1004, 32'h0BAD_F00D); #1;
        check("t4_load_ok", {31'b0, data_data_ok}, 32'd1);
        check("t4_mem_unchanged", data_rdata, 32'h1234_4A5A);
        check("t4_word_wen", {28'b0, sram_wen}, 32'b1111);

        // 5. reset lands between grant and response: response dropped
        @(negedge clk); dreq(1'b0, 2'd2, 32'h1000, 32'h0);
        @(posedge clk); #2; resetn = 1'b0; idle();
        @(negedge clk); #1;
        check("t5_dropped_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
        @(negedge clk); resetn = 1'b1; #1;
        check("t5_no_ok_after_rel", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
        // Counter cleared: simultaneous requests see four data grants first.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); inst_req = 1'b1; inst_addr = 32'h3000;
            dreq(1'b0, 2'd2, 32'h1000, 32'h0); #1;
            check($sformatf("t5_grant_d[%0d]", k), {31'b0, data_addr_ok}, (k < 4) ? 32'd1 : 32'd0);
            if (k == 1) check("t5_first_rdata", data_rdata, 32'h1234_4A5A);
        end

        // 6. alternating load/fetch, one response per accept, no bubbles
        @(negedge clk); idle();
        prev_d = 1'b0; prev_a = 32'h3000;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            idle();
            exp_d = (k % 2) == 0;
            if (exp_d) begin cur_a = 32'h4000 + 32'(4*k); dreq(1'b0, 2'd2, cur_a, 32'h0); end
            else begin cur_a = 32'h8000 + 32'(4*k); inst_req = 1'b1; inst_addr = cur_a; end
            #1;
            check($sformatf("t6_accept[%0d]", k), {30'b0, data_addr_ok, inst_addr_ok},
                  exp_d ? 32'd2 : 32'd1);
            check($sformatf("t6_owner[%0d]", k), {30'b0, data_data_ok, inst_data_ok},
                  prev_d ? 32'd2 : 32'd1);
            check($sformatf("t6_rdata[%0d]", k), prev_d ? data_rdata : inst_rdata,
                  init_word(prev_a));
            prev_d = exp_d; prev_a = cur_a;
        end
        @(negedge clk); idle(); #1;
        check("t6_last_ok", {30'b0, data_data_ok, inst_data_ok}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
